// File: rtl/imem_pkg.sv
// Shared types and sizing for the boot-loaded instruction memory.
package imem_pkg;

   localparam int unsigned ADDR_W    = 9;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned DEPTH     = 512;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_ERR  = 2'd2
   } imem_state_t;

   typedef logic [DATA_W-1:0] instr_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one combinational read port, no reset.
module imem_array
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  instr_t            wdata,
   input  logic [ADDR_W-1:0] raddr,
   output instr_t            rdata
);

   instr_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with a boot FSM that streams an image in from word 0
// and holds the core until a complete image is present.
module imem_boot_loader
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   output instr_t            instr,
   output logic              fetch_oob,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  instr_t            ld_data,
   input  logic              ld_last,
   input  logic              reload,
   output logic              core_hold,
   output logic              load_err,
   output logic [ADDR_W:0]   loaded_words,
   output imem_state_t       state_dbg
);

   // Handshake: a word moves when ld_valid && ld_ready at a rising clk edge.
   // ld_ready depends only on state; ld_data/ld_last are sampled only with ld_valid.

   imem_state_t     state_q, state_d;
   logic [ADDR_W:0] count_q, count_d;
   logic            hold_q, hold_d;
   logic            err_q, err_d;
   logic            xfer;
   logic            we;
   instr_t          rdata;
   logic            in_range;

   assign ld_ready = (state_q == S_LOAD);
   assign xfer     = ld_valid && ld_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LOAD;
         count_q <= '0;
         hold_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hold_d  = hold_q;
      err_d   = err_q;
      we      = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            if (xfer) begin
               we      = 1'b1;
               count_d = count_q + 1'b1;
               if (ld_last) begin
                  state_d = S_RUN;
                  hold_d  = 1'b0;
               end else if (count_q == (ADDR_W+1)'(DEPTH - 1)) begin
                  // Image filled every word without a terminator.
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (reload) begin
               state_d = S_LOAD;
               count_d = '0;
               hold_d  = 1'b1;
            end
         end
         S_ERR: begin
            if (reload) begin
               state_d = S_LOAD;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_LOAD;
            count_d = '0;
            hold_d  = 1'b1;
            err_d   = 1'b0;
         end
      endcase
   end

   imem_array u_array (
      .clk   (clk),
      .we    (we),
      .waddr (count_q[ADDR_W-1:0]),
      .wdata (ld_data),
      .raddr (pc),
      .rdata (rdata)
   );

   assign in_range = ({1'b0, pc} < count_q);

   always_comb begin
      instr     = NOP_INSTR;
      fetch_oob = 1'b0;
      if (state_q == S_RUN) begin
         if (in_range) begin
            instr = rdata;
         end else begin
            fetch_oob = 1'b1;
         end
      end
   end

   assign core_hold    = hold_q;
   assign load_err     = err_q;
   assign loaded_words = count_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: directed boot, overflow, reload and reset scenarios.
module tb_imem_boot_loader;
   import imem_pkg::*;

   localparam int W = 46;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] pc = '0;
   instr_t            instr;
   logic              fetch_oob;
   logic              ld_valid = 1'b0;
   logic              ld_ready;
   instr_t            ld_data = '0;
   logic              ld_last = 1'b0;
   logic              reload = 1'b0;
   logic              core_hold;
   logic              load_err;
   logic [ADDR_W:0]   loaded_words;
   imem_state_t       state_dbg;

   logic              chk_r = 1'b0;
   logic [W-1:0]      exp_q[$];
   string             nm_q[$];
   int                checks = 0;
   int                errors = 0;

   imem_boot_loader dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .instr        (instr),
      .fetch_oob    (fetch_oob),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .reload       (reload),
      .core_hold    (core_hold),
      .load_err     (load_err),
      .loaded_words (loaded_words),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic h, input logic e, input logic r,
                                       input logic o, input logic [9:0] w, input logic [31:0] i);
      return {h, e, r, o, w, i};
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (chk_r) begin
         logic [W-1:0] act, e;
         string n;
         act = {core_hold, load_err, ld_ready, fetch_oob, loaded_words, instr};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample: got %h with no expectation queued", act);
         end else begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got hold=%0b err=%0b rdy=%0b oob=%0b words=%0d instr=%h, want hold=%0b err=%0b rdy=%0b oob=%0b words=%0d instr=%h",
                        n, act[45], act[44], act[43], act[42], act[41:32], act[31:0],
                        e[45], e[44], e[43], e[42], e[41:32], e[31:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [W-1:0] e);
      nm_q.push_back(n);
      exp_q.push_back(e);
      chk_r = 1'b1;
      step();
      chk_r = 1'b0;
   endtask

   task automatic load(input logic [31:0] base, input int n, input logic with_last);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = base + 32'(i);
         ld_last  = with_last && (i == n - 1);
         step();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      step();
      reload = 1'b0;
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      repeat (2) step();
      rst = 1'b0;
      chk("reset", mk(1, 0, 1, 0, 0, NOP));

      // 1: three-word image, valid held high
      ld_valid = 1'b1; ld_data = 32'h0010_0093; ld_last = 1'b0;
      chk("t1_w0", mk(1, 0, 1, 0, 0, NOP));
      ld_data = 32'h0020_8113;
      chk("t1_w1", mk(1, 0, 1, 0, 1, NOP));
      ld_data = 32'h0000_0063; ld_last = 1'b1;
      chk("t1_w2", mk(1, 0, 1, 0, 2, NOP));
      ld_valid = 1'b0; ld_last = 1'b0; pc = 9'd1;
      chk("t1_pc1", mk(0, 0, 0, 0, 3, 32'h0020_8113));
      pc = 9'd3;
      chk("t1_pc3_oob", mk(0, 0, 0, 1, 3, NOP));
      pc = 9'd0; ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
      chk("t1_stream_ignored", mk(0, 0, 0, 0, 3, 32'h0010_0093));
      ld_valid = 1'b0;
      reload = 1'b1;
      chk("t2_reload_cycle", mk(0, 0, 0, 0, 3, 32'h0010_0093));
      reload = 1'b0;

      // 2: gaps in valid
      ld_valid = 1'b1; ld_data = 32'h1111_1111; step();
      ld_valid = 1'b0; ld_data = 32'h2222_2222;
      chk("t2_gap1", mk(1, 0, 1, 0, 1, NOP));
      ld_data = 32'hBADB_AD00;
      chk("t2_gap2", mk(1, 0, 1, 0, 1, NOP));
      ld_valid = 1'b1; ld_data = 32'h2222_2222; step();
      ld_data = 32'h3333_3333; ld_last = 1'b1; step();
      ld_valid = 1'b0; ld_last = 1'b0;
      pc = 9'd0; chk("t2_pc0", mk(0, 0, 0, 0, 3, 32'h1111_1111));
      pc = 9'd1; chk("t2_pc1", mk(0, 0, 0, 0, 3, 32'h2222_2222));
      pc = 9'd2; chk("t2_pc2", mk(0, 0, 0, 0, 3, 32'h3333_3333));
      pc = 9'd3; chk("t2_pc3_oob", mk(0, 0, 0, 1, 3, NOP));
      pulse_reload();

      // 3: overflow without last
      load(32'hA500_0000, 512, 1'b0);
      ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; pc = 9'd5;
      chk("t3_err", mk(1, 1, 0, 0, 512, NOP));
      chk("t3_513_not_taken", mk(1, 1, 0, 0, 512, NOP));
      ld_valid = 1'b0;
      reload = 1'b1;
      chk("t3_reload_cycle", mk(1, 1, 0, 0, 512, NOP));
      reload = 1'b0;
      chk("t3_after_reload", mk(1, 0, 1, 0, 0, NOP));

      // 4: full 512-word image, last on final word
      load(32'h5A00_0000, 512, 1'b1);
      pc = 9'd511; chk("t4_pc511", mk(0, 0, 0, 0, 512, 32'h5A00_01FF));
      pc = 9'd0;   chk("t4_pc0", mk(0, 0, 0, 0, 512, 32'h5A00_0000));
      pc = 9'd256; chk("t4_pc256", mk(0, 0, 0, 0, 512, 32'h5A00_0100));

      // 5: reload at run time
      pulse_reload();
      load(32'hC000_0000, 4, 1'b1);
      pc = 9'd3; chk("t5_img4_pc3", mk(0, 0, 0, 0, 4, 32'hC000_0003));
      pulse_reload();
      pc = 9'd1; chk("t5_hold_nop", mk(1, 0, 1, 0, 0, NOP));
      load(32'hE000_0000, 2, 1'b1);
      pc = 9'd0; chk("t5_pc0", mk(0, 0, 0, 0, 2, 32'hE000_0000));
      pc = 9'd1; chk("t5_pc1", mk(0, 0, 0, 0, 2, 32'hE000_0001));
      pc = 9'd2; chk("t5_pc2_oob", mk(0, 0, 0, 1, 2, NOP));

      // 6: reset mid-load
      pulse_reload();
      load(32'hF000_0000, 5, 1'b0);
      rst = 1'b1;
      chk("t6_in_rst", mk(1, 0, 1, 0, 0, NOP));
      rst = 1'b0;
      chk("t6_after_rst", mk(1, 0, 1, 0, 0, NOP));
      load(32'h7000_0000, 3, 1'b1);
      pc = 9'd0; chk("t6_pc0", mk(0, 0, 0, 0, 3, 32'h7000_0000));
      pc = 9'd2; chk("t6_pc2", mk(0, 0, 0, 0, 3, 32'h7000_0002));
      pc = 9'd3; chk("t6_pc3_oob", mk(0, 0, 0, 1, 3, NOP));

      repeat (2) step();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations: got %0d unchecked, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
